// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - stopwatch states, digit moduli and 7-segment decode
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } sw_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit 3 is tens of seconds, so it wraps at 6.
  function automatic logic [3:0] digit_mod(input int idx);
    return (idx == 3) ? 4'd6 : 4'd10;
  endfunction

  // Returns {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_mux_n_if.sv
// rtl/stopwatch_mux_n_if.sv - button inputs and display/status outputs of the stopwatch
interface stopwatch_mux_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  btn_start;
  logic                  btn_lap;
  logic                  btn_clear;
  logic [NUM_DIGITS-1:0] an_n;
  logic [7:0]            seg_n;
  logic                  running;
  logic                  lap_held;
  logic                  overflow;

  modport master (
    output btn_start, btn_lap, btn_clear,
    input  an_n, seg_n, running, lap_held, overflow
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    output an_n, seg_n, running, lap_held, overflow
  );
endinterface

// File: rtl/stopwatch_mux_n_sevenseg_scan.sv
// rtl/stopwatch_mux_n_sevenseg_scan.sv - time-multiplexed common-anode digit scanner
// Outputs are registered; digit 0 is driven from the first clock after reset.
module sevenseg_scan
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 10000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIGITS-1:0][3:0] digits_i,
  input  logic [NUM_DIGITS-1:0]      dp_mask_i,
  output logic [NUM_DIGITS-1:0]      an_n_o,
  output logic [7:0]                 seg_n_o
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [7:0]            seg_n_q, seg_n_d;

  always_comb begin
    div_d   = div_q + DW'(1);
    idx_d   = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_n_d = {~dp_mask_i[idx_q], bcd_to_seg(digits_i[idx_q])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      an_n_q  <= '1;
      seg_n_q <= SEG_BLANK;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
    end
  end

  assign an_n_o  = an_n_q;
  assign seg_n_o = seg_n_q;

endmodule

// File: rtl/stopwatch_mux_n.sv
// rtl/stopwatch_mux_n.sv - N-digit BCD stopwatch with multiplexed 7-segment display
// Optional lap-freeze feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_mux_n
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 10_000_000,
  parameter int TICK_HZ    = 100,
  parameter int SCAN_HZ    = 1000
) (
  input logic              clk,
  input logic              rst,
  stopwatch_mux_n_if.slave sw_io
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] DP_MASK = (NUM_DIGITS > 2) ? NUM_DIGITS'(4) : '0;

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic [NB-1:0]              btn_now, btn_prev_q, btn_edge;
  logic                       edge_start, edge_clear;
  sw_state_e                  state_q, state_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [NUM_DIGITS-1:0][3:0] count_q, count_d, disp_digits;
  logic                       ovf_q, ovf_d;
  logic                       clr_act, counting, tick, carry;

`ifdef STOPWATCH_LAP_EN
  logic                       edge_lap, snap_load;
  logic [NUM_DIGITS-1:0][3:0] snap_q;
  assign btn_now  = {sw_io.btn_lap, sw_io.btn_clear, sw_io.btn_start};
  assign edge_lap = btn_edge[2];
`else
  assign btn_now  = {sw_io.btn_clear, sw_io.btn_start};
`endif

  // Prev resets to 1 so a button held through reset does not register as an edge.
  assign btn_edge   = btn_now & ~btn_prev_q;
  assign edge_start = btn_edge[0];
  assign edge_clear = btn_edge[1];

  always_comb begin
    state_d = state_q;
    clr_act = 1'b0;
`ifdef STOPWATCH_LAP_EN
    snap_load = 1'b0;
`endif
    case (state_q)
      IDLE: if (edge_clear) clr_act = 1'b1;
            else if (edge_start) state_d = RUN;
      RUN:  if (edge_start) state_d = STOP;
`ifdef STOPWATCH_LAP_EN
            else if (edge_lap) begin
              state_d   = LAP;
              snap_load = 1'b1;
            end
`endif
      STOP: if (edge_clear) begin
              state_d = IDLE;
              clr_act = 1'b1;
            end else if (edge_start) state_d = RUN;
      LAP:  if (edge_start) state_d = STOP;
`ifdef STOPWATCH_LAP_EN
            else if (edge_lap) state_d = RUN;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PW'(TICK_DIV - 1));

  // Ripple carry through the digits in the tick cycle; a carry out of the top is overflow.
  always_comb begin
    count_d = count_q;
    carry   = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] == digit_mod(i) - 4'd1) begin
          count_d[i] = '0;
        end else begin
          count_d[i] = count_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    ovf_d   = ovf_q | carry;
    presc_d = presc_q;
    if (counting) presc_d = tick ? '0 : presc_q + PW'(1);
    if (clr_act) begin
      count_d = '0;
      ovf_d   = 1'b0;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= '1;
      state_q    <= IDLE;
      presc_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      btn_prev_q <= btn_now;
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (rst)            snap_q <= '0;
    else if (snap_load) snap_q <= count_q;
  end
  assign disp_digits    = (state_q == LAP) ? snap_q : count_q;
  assign sw_io.lap_held = (state_q == LAP);
`else
  assign disp_digits    = count_q;
  assign sw_io.lap_held = 1'b0;
`endif

  assign sw_io.running  = counting;
  assign sw_io.overflow = ovf_q;

  sevenseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .digits_i  (disp_digits),
    .dp_mask_i (DP_MASK),
    .an_n_o    (sw_io.an_n),
    .seg_n_o   (sw_io.seg_n)
  );

endmodule

// File: tb/tb_stopwatch_mux_n.sv
// tb/tb_stopwatch_mux_n.sv - self-checking bench for stopwatch_mux_n (lap tests under STOPWATCH_LAP_EN)
module tb_stopwatch_mux_n;
  localparam int ND    = 4;
  localparam int DIV   = 10;
  localparam int SDIV  = 4;
  localparam int RANGE = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  stopwatch_mux_n_if #(.NUM_DIGITS(ND)) sw ();

  stopwatch_mux_n #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .SCAN_HZ    (250)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_io (sw)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time is total cycles spent running since the last clear.
  int         m_state;
  longint     m_runcyc;
  int         m_snap;
  int         m_edges;
  bit         m_pst, m_plp, m_pcl;
  logic [3:0] m_an;
  logic [7:0] m_seg;

  function automatic int digit_of(input int val, input int idx);
    int mods [4] = '{10, 10, 10, 6};
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * mods[i];
    return (val / p) % mods[idx];
  endfunction

  always @(posedge clk) begin : model
    int cur, disp, idx;
    bit es, el, ec;
    if (rst) begin
      m_state = 0; m_runcyc = 0; m_snap = 0; m_edges = 0;
      m_pst = 1; m_plp = 1; m_pcl = 1;
      m_an = 4'hF; m_seg = 8'hFF;
    end else begin
      cur   = int'((m_runcyc / DIV) % RANGE);
      disp  = (m_state == 3) ? m_snap : cur;
      idx   = (m_edges / SDIV) % ND;
      m_an  = ~(4'b0001 << idx);
      m_seg = {1'(idx != 2), seg_tab[digit_of(disp, idx)]};
      m_edges++;
      es = sw.btn_start && !m_pst;
      el = sw.btn_lap   && !m_plp;
      ec = sw.btn_clear && !m_pcl;
      m_pst = sw.btn_start; m_plp = sw.btn_lap; m_pcl = sw.btn_clear;
      if (m_state == 1 || m_state == 3) m_runcyc++;
      case (m_state)
        0: if (ec) m_runcyc = 0; else if (es) m_state = 1;
        1: if (es) m_state = 2;
`ifdef STOPWATCH_LAP_EN
           else if (el) begin m_state = 3; m_snap = cur; end
`endif
        2: if (ec) begin m_state = 0; m_runcyc = 0; end else if (es) m_state = 1;
        3: if (es) m_state = 2; else if (el) m_state = 1;
        default: m_state = 0;
      endcase
    end
  end

  task automatic read_value(output int v);
    int         dig [4];
    logic [3:0] one = 4'b0001;
    for (int i = 0; i < 4; i++) dig[i] = 15;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (sw.an_n == ~(one << i))
          for (int s = 0; s < 10; s++)
            if (sw.seg_n[6:0] == seg_tab[s]) dig[i] = s;
    end
    v = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
  endtask

  task automatic press_clear();
    @(negedge clk) sw.btn_clear = 1'b1;
    @(negedge clk) sw.btn_clear = 1'b0;
  endtask

  // Start, let exactly n counting cycles elapse, then stop.
  task automatic run_cycles(input int n);
    @(negedge clk) sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
    repeat (n - 1) @(negedge clk);
    sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw.btn_start = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sw.an_n !== 4'hF) begin bad++; $display("FAIL reset_an: got %b want 1111", sw.an_n); end
    total++; if (sw.seg_n !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", sw.seg_n); end
    total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", sw.running); end
    total++; if (sw.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", sw.overflow); end
    total++; if (sw.lap_held !== 1'b0) begin bad++; $display("FAIL reset_lap_held: got %b want 0", sw.lap_held); end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int         idx;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx     = ((k - 1) / 4) % 4;
      exp_an  = ~(one << idx);
      exp_seg = {1'(idx != 2), seg_tab[0]};
      total++; if (sw.an_n !== exp_an) begin bad++; $display("FAIL scan_an[%0d]: got %b want %b", k, sw.an_n, exp_an); end
      total++; if (sw.seg_n !== exp_seg) begin bad++; $display("FAIL scan_seg[%0d]: got %h want %h", k, sw.seg_n, exp_seg); end
    end
  endtask

  task automatic test_held_start();
    total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL held_start: got running=%b want 0", sw.running); end
    sw.btn_start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL held_release: got running=%b want 0", sw.running); end
  endtask

  task automatic test_start_count();
    int v;
    @(negedge clk) sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
    total++; if (sw.running !== 1'b1) begin bad++; $display("FAIL start_latency: got running=%b want 1", sw.running); end
    repeat (9) @(negedge clk);
    sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
    total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL stop: got running=%b want 0", sw.running); end
    read_value(v);
    total++; if (v !== 1) begin bad++; $display("FAIL first_tick: got %0d want 1", v); end
    press_clear();
    run_cycles(9);
    read_value(v);
    total++; if (v !== 0) begin bad++; $display("FAIL before_tick: got %0d want 0", v); end
    press_clear();
    run_cycles(1000);
    read_value(v);
    total++; if (v !== 100) begin bad++; $display("FAIL count_100: got %0d want 100", v); end
  endtask

  task automatic test_resume();
    int v;
    press_clear();
    run_cycles(25);
    repeat (50) @(negedge clk);
    run_cycles(4);
    read_value(v);
    total++; if (v !== 2) begin bad++; $display("FAIL resume_4: got %0d want 2", v); end
    press_clear();
    run_cycles(25);
    repeat (50) @(negedge clk);
    run_cycles(5);
    read_value(v);
    total++; if (v !== 3) begin bad++; $display("FAIL resume_5: got %0d want 3", v); end
  endtask

  task automatic test_clear_start();
    int v;
    press_clear();
    run_cycles(30);
    @(negedge clk) begin sw.btn_clear = 1'b1; sw.btn_start = 1'b1; end
    @(negedge clk) begin sw.btn_clear = 1'b0; sw.btn_start = 1'b0; end
    total++; if (sw.running !== 1'b0) begin bad++; $display("FAIL clear_start_running: got %b want 0", sw.running); end
    read_value(v);
    total++; if (v !== 0) begin bad++; $display("FAIL clear_start_value: got %0d want 0", v); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    int v;
    press_clear();
    @(negedge clk) sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
    repeat (120) @(negedge clk);
    sw.btn_lap = 1'b1;
    @(negedge clk) sw.btn_lap = 1'b0;
    total++; if (sw.lap_held !== 1'b1) begin bad++; $display("FAIL lap_enter: got lap_held=%b want 1", sw.lap_held); end
    total++; if (sw.running !== 1'b1) begin bad++; $display("FAIL lap_running: got %b want 1", sw.running); end
    repeat (30) @(negedge clk);
    read_value(v);
    total++; if (v !== 12) begin bad++; $display("FAIL lap_frozen: got %0d want 12", v); end
    sw.btn_lap = 1'b1;
    @(negedge clk) sw.btn_lap = 1'b0;
    total++; if (sw.lap_held !== 1'b0) begin bad++; $display("FAIL lap_release: got lap_held=%b want 0", sw.lap_held); end
    @(negedge clk) sw.btn_start = 1'b1;
    @(negedge clk) sw.btn_start = 1'b0;
    read_value(v);
    total++; if (v !== 17) begin bad++; $display("FAIL lap_live: got %0d want 17", v); end
  endtask
`endif

  task automatic test_overflow();
    int v;
    press_clear();
    run_cycles(59990);
    read_value(v);
    total++; if (v !== 5999) begin bad++; $display("FAIL max_count: got %0d want 5999", v); end
    total++; if (sw.overflow !== 1'b0) begin bad++; $display("FAIL no_overflow: got %b want 0", sw.overflow); end
    run_cycles(10);
    read_value(v);
    total++; if (v !== 0) begin bad++; $display("FAIL wrap: got %0d want 0", v); end
    total++; if (sw.overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", sw.overflow); end
    press_clear();
    total++; if (sw.overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b want 0", sw.overflow); end
  endtask

  task automatic test_random(input int n);
    logic exp_run, exp_lap, exp_ovf;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_run = (m_state == 1) || (m_state == 3);
      exp_lap = (m_state == 3);
      exp_ovf = (m_runcyc / DIV) >= RANGE;
      total++;
      if (sw.an_n !== m_an || sw.seg_n !== m_seg || sw.running !== exp_run ||
          sw.lap_held !== exp_lap || sw.overflow !== exp_ovf) begin
        bad++;
        $display("FAIL random[%0d]: got an=%b seg=%h run=%b lap=%b ovf=%b want an=%b seg=%h run=%b lap=%b ovf=%b",
                 i, sw.an_n, sw.seg_n, sw.running, sw.lap_held, sw.overflow,
                 m_an, m_seg, exp_run, exp_lap, exp_ovf);
      end
      if ($urandom_range(0, 9) == 0)  sw.btn_start = ~sw.btn_start;
      if ($urandom_range(0, 7) == 0)  sw.btn_lap   = ~sw.btn_lap;
      if ($urandom_range(0, 11) == 0) sw.btn_clear = ~sw.btn_clear;
    end
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_clear = 1'b0;
  endtask

  initial begin
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_clear = 1'b0;
    test_reset();
    test_scan();
    test_held_start();
    test_start_count();
    test_resume();
    test_clear_start();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_overflow();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
